// File: rtl/button_event_ctrl.sv
// button_event_ctrl: debounces four push-buttons and turns presses and held buttons into a handshaked event stream.
//   cclk       system clock, rising edge
//   clr        asynchronous active-high reset
//   btn        raw button levels, bit i is button i
//   btn_level  debounced button levels
//   evt_valid  event present on evt_code/evt_repeat
//   evt_code   index of the button that raised the event
//   evt_repeat 0 = press event, 1 = auto-repeat event
//   evt_ready  consumer accepts the event
//   overflow   sticky: a press event was lost
module button_event_ctrl #(
    parameter int SAMPLE_DIV   = 50000,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic       cclk,
    input  logic       clr,
    input  logic [3:0] btn,
    output logic [3:0] btn_level,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       evt_repeat,
    input  logic       evt_ready,
    output logic       overflow
);
    localparam int PW   = $clog2(SAMPLE_DIV);
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   pcnt;
    logic            tick;
    logic [3:0]      s1, s2, s3, prev_level, pending, pending_n, press, pend_clr;
    logic            rpt_pending, rpt_set, rpt_drop, load, take_pend, take_rpt, lost;
    logic [1:0]      owner, owner_n;
    logic [CW-1:0]   rcnt, rcnt_n, rcnt_inc;

    function automatic logic [1:0] lsb_idx(input logic [3:0] v);
        return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
    endfunction

    assign tick      = pcnt == PW'(SAMPLE_DIV - 1);
    assign btn_level = s1 & s2 & s3;
    assign press     = btn_level & ~prev_level;
    assign load      = ~evt_valid | evt_ready;
    assign take_pend = load & |pending;
    assign take_rpt  = load & ~|pending & rpt_pending;
    assign pend_clr  = take_pend ? 4'b0001 << lsb_idx(pending) : 4'b0000;
    // A press landing in the same cycle its pending bit is consumed re-arms the bit without loss.
    assign pending_n = (pending & ~pend_clr) | press;
    assign lost      = |(press & pending & ~pend_clr);
    assign rcnt_inc  = rcnt + CW'(1);

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rcnt_n   = rcnt;
        rpt_set  = 1'b0;
        rpt_drop = 1'b0;
        case (state)
            IDLE: begin
                if (|press) begin
                    owner_n = lsb_idx(press);
                    rcnt_n  = '0;
                    state_n = DELAY;
                end
            end
            DELAY, REPEAT: begin
                // Releasing the owning button wins over a counter match on the same cycle.
                if (!btn_level[owner]) begin
                    state_n  = IDLE;
                    rpt_drop = 1'b1;
                end else if (tick) begin
                    if (rcnt_inc == CW'(state == DELAY ? REPEAT_DELAY : REPEAT_RATE)) begin
                        rpt_set = 1'b1;
                        rcnt_n  = '0;
                        state_n = REPEAT;
                    end else begin
                        rcnt_n = rcnt_inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            pcnt        <= '0;
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
            prev_level  <= '0;
            pending     <= '0;
            rpt_pending <= 1'b0;
            rcnt        <= '0;
            owner       <= '0;
            overflow    <= 1'b0;
            evt_valid   <= 1'b0;
            evt_code    <= '0;
            evt_repeat  <= 1'b0;
        end else begin
            state       <= state_n;
            pcnt        <= tick ? '0 : pcnt + PW'(1);
            s1          <= tick ? btn : s1;
            s2          <= tick ? s1 : s2;
            s3          <= tick ? s2 : s3;
            prev_level  <= btn_level;
            pending     <= pending_n;
            // A repeat raised while one is already queued simply merges into it.
            rpt_pending <= rpt_drop ? 1'b0 : rpt_set ? 1'b1 : take_rpt ? 1'b0 : rpt_pending;
            rcnt        <= rcnt_n;
            owner       <= owner_n;
            overflow    <= overflow | lost;
            if (load) begin
                evt_valid  <= take_pend | take_rpt;
                evt_code   <= take_pend ? lsb_idx(pending) : take_rpt ? owner : 2'd0;
                evt_repeat <= take_rpt;
            end
        end
    end
endmodule
